// File: rtl/hazard_ctrl_mc.sv
// Hazard unit for the 5-stage MIPS pipeline: per-stage stall/flush, ID/EX bypass selects,
// parametrised bubble counts, multi-cycle MDU wait and exception priority.
module hazard_ctrl_mc #(
  parameter int REG_AW       = 7,
  parameter int LOAD_BUBBLES = 1,
  parameter int BR_BUBBLES   = 1,
  parameter int BRLD_BUBBLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exc_flush,
  input  logic              exc_stall,
  input  logic              branch_d,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic [REG_AW-1:0] wreg_e,
  input  logic [REG_AW-1:0] wreg_m,
  input  logic [REG_AW-1:0] wreg_w,
  input  logic              regwr_e,
  input  logic              regwr_m,
  input  logic              regwr_w,
  input  logic              memrd_e,
  input  logic              memrd_m,
  input  logic              mdu_start,
  input  logic              mdu_done,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              stall_w,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              flush_w,
  output logic [1:0]        fwd_a_d,
  output logic [1:0]        fwd_b_d,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic              busy
);

  if (LOAD_BUBBLES < 1 || LOAD_BUBBLES > 7) begin : g_bad_load
    $error("LOAD_BUBBLES must be in 1..7");
  end
  if (BR_BUBBLES < 0 || BR_BUBBLES > 7) begin : g_bad_br
    $error("BR_BUBBLES must be in 0..7");
  end
  if (BRLD_BUBBLES < 1 || BRLD_BUBBLES > 7) begin : g_bad_brld
    $error("BRLD_BUBBLES must be in 1..7");
  end

  localparam logic [2:0] LOAD_N = 3'(LOAD_BUBBLES);
  localparam logic [2:0] BR_N   = 3'(BR_BUBBLES);
  localparam logic [2:0] BRLD_N = 3'(BRLD_BUBBLES);

  typedef enum logic [1:0] {IDLE, BUBBLE, MDU_WAIT, EXC} state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] bub_n;
  logic       hit_e, mdu_hz;
  logic       bub, mdu_o, hold_all, flush_all;

  // Load data is not yet available in MEM, so a load there falls through to WB/regfile.
  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                         input logic              rm,
                                         input logic [REG_AW-1:0] wm,
                                         input logic              ldm,
                                         input logic              rw,
                                         input logic [REG_AW-1:0] ww);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0) begin
      if (rm && wm == src && !ldm) sel = 2'b10;
      else if (rw && ww == src)   sel = 2'b01;
    end
    return sel;
  endfunction

  assign hit_e  = (wreg_e != '0) && (wreg_e == rs_d || wreg_e == rt_d);
  assign mdu_hz = mdu_start && !mdu_done;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bub_n     = 3'd0;
    bub       = 1'b0;
    mdu_o     = 1'b0;
    hold_all  = 1'b0;
    flush_all = 1'b0;
    if (branch_d && memrd_e && hit_e)                 bub_n = BRLD_N;
    else if (branch_d && regwr_e && !memrd_e && hit_e) bub_n = BR_N;
    else if (!branch_d && memrd_e && hit_e)           bub_n = LOAD_N;

    if (rst) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
    end else if (exc_flush) begin
      flush_all = 1'b1;
      state_d   = EXC;
      cnt_d     = 3'd0;
    end else if (state_q == EXC) begin
      flush_all = 1'b1;
      state_d   = IDLE;
    end else if (exc_stall) begin
      hold_all = 1'b1;
    end else if (mdu_hz) begin
      mdu_o   = 1'b1;
      state_d = MDU_WAIT;
      cnt_d   = 3'd0;
    end else if (state_q == MDU_WAIT) begin
      state_d = IDLE;
    end else if (state_q == BUBBLE) begin
      // cnt holds the bubble cycles still owed, including this one.
      bub   = 1'b1;
      cnt_d = cnt_q - 3'd1;
      if (cnt_q <= 3'd1) state_d = IDLE;
    end else if (bub_n != 3'd0) begin
      bub = 1'b1;
      if (bub_n > 3'd1) begin
        state_d = BUBBLE;
        cnt_d   = bub_n - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_f = hold_all | bub | mdu_o;
  assign stall_d = hold_all | bub | mdu_o;
  assign stall_e = hold_all | mdu_o;
  assign stall_m = hold_all;
  assign stall_w = hold_all;
  assign flush_d = flush_all;
  assign flush_e = flush_all | bub;
  assign flush_m = flush_all | mdu_o;
  assign flush_w = flush_all;
  assign busy    = !rst && (state_q != IDLE);

  assign fwd_a_d = rst ? 2'b00 : fwd_sel(rs_d, regwr_m, wreg_m, memrd_m, regwr_w, wreg_w);
  assign fwd_b_d = rst ? 2'b00 : fwd_sel(rt_d, regwr_m, wreg_m, memrd_m, regwr_w, wreg_w);
  assign fwd_a_e = rst ? 2'b00 : fwd_sel(rs_e, regwr_m, wreg_m, memrd_m, regwr_w, wreg_w);
  assign fwd_b_e = rst ? 2'b00 : fwd_sel(rt_e, regwr_m, wreg_m, memrd_m, regwr_w, wreg_w);

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Scoreboard bench for hazard_ctrl_mc: directed pipeline scenarios followed by random traffic,
// checked against a counter-based reference model of the hazard rules.
module tb_hazard_ctrl_mc;
  localparam int AW   = 7;
  localparam int LOADN = 1;
  localparam int BRN   = 3;
  localparam int BRLDN = 2;

  typedef struct packed {
    logic       sf, sd, se, sm, sw;
    logic       fd, fe, fm, fw;
    logic [1:0] fad, fbd, fae, fbe;
    logic       busy;
  } outs_t;

  logic clk;
  logic rst, exc_flush, exc_stall, branch_d;
  logic [AW-1:0] rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w;
  logic regwr_e, regwr_m, regwr_w, memrd_e, memrd_m, mdu_start, mdu_done;
  logic stall_f, stall_d, stall_e, stall_m, stall_w;
  logic flush_d, flush_e, flush_m, flush_w;
  logic [1:0] fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e;
  logic busy;

  outs_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Reference model state: bubbles still owed, MDU wait pending, exception cycle pending.
  int m_bub = 0;
  bit m_mdu = 0;
  bit m_exc = 0;

  hazard_ctrl_mc #(.REG_AW(AW), .LOAD_BUBBLES(LOADN), .BR_BUBBLES(BRN),
                   .BRLD_BUBBLES(BRLDN)) dut (
    .clk(clk), .rst(rst), .exc_flush(exc_flush), .exc_stall(exc_stall),
    .branch_d(branch_d), .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .wreg_e(wreg_e), .wreg_m(wreg_m), .wreg_w(wreg_w),
    .regwr_e(regwr_e), .regwr_m(regwr_m), .regwr_w(regwr_w),
    .memrd_e(memrd_e), .memrd_m(memrd_m), .mdu_start(mdu_start), .mdu_done(mdu_done),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .stall_w(stall_w), .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
    .flush_w(flush_w), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .fwd_a_e(fwd_a_e),
    .fwd_b_e(fwd_b_e), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] exp_fwd(input logic [AW-1:0] src);
    if (rst || src == 0) return 2'b00;
    if (regwr_m && wreg_m == src && !memrd_m) return 2'b10;
    if (regwr_w && wreg_w == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int hazard_bubbles();
    bit hit;
    hit = (wreg_e != 0) && (wreg_e == rs_d || wreg_e == rt_d);
    if (!hit) return 0;
    if (branch_d) return memrd_e ? BRLDN : (regwr_e ? BRN : 0);
    return memrd_e ? LOADN : 0;
  endfunction

  task automatic clr();
    rst = 0; exc_flush = 0; exc_stall = 0; branch_d = 0;
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0; wreg_e = 0; wreg_m = 0; wreg_w = 0;
    regwr_e = 0; regwr_m = 0; regwr_w = 0; memrd_e = 0; memrd_m = 0;
    mdu_start = 0; mdu_done = 0;
  endtask

  // Predict this cycle's outputs from the current inputs, queue them, advance the model.
  task automatic tick();
    outs_t e;
    int n;
    e = '0;
    e.fad = exp_fwd(rs_d);
    e.fbd = exp_fwd(rt_d);
    e.fae = exp_fwd(rs_e);
    e.fbe = exp_fwd(rt_e);
    e.busy = !rst && (m_exc || m_mdu || m_bub > 0);
    if (rst) begin
      e = '0; m_bub = 0; m_mdu = 0; m_exc = 0;
    end else if (exc_flush) begin
      {e.fd, e.fe, e.fm, e.fw} = 4'hF;
      m_exc = 1; m_bub = 0; m_mdu = 0;
    end else if (m_exc) begin
      {e.fd, e.fe, e.fm, e.fw} = 4'hF;
      m_exc = 0;
    end else if (exc_stall) begin
      {e.sf, e.sd, e.se, e.sm, e.sw} = 5'h1F;
    end else if (mdu_start && !mdu_done) begin
      {e.sf, e.sd, e.se, e.fm} = 4'hF;
      m_mdu = 1; m_bub = 0;
    end else if (m_mdu) begin
      m_mdu = 0;
    end else if (m_bub > 0) begin
      {e.sf, e.sd, e.fe} = 3'h7;
      m_bub = m_bub - 1;
    end else begin
      n = hazard_bubbles();
      if (n > 0) begin
        {e.sf, e.sd, e.fe} = 3'h7;
        m_bub = n - 1;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    outs_t a, x;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      a = '{stall_f, stall_d, stall_e, stall_m, stall_w, flush_d, flush_e, flush_m, flush_w,
            fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, busy};
      n_cmp++;
      if (a !== x) begin
        n_bad++;
        $display("FAIL outs cycle %0d: got %b want %b (sf sd se sm sw fd fe fm fw fad fbd fae fbe busy)",
                 cyc, a, x);
      end
      cyc++;
    end
  end

  function automatic logic [AW-1:0] rid();
    if ($urandom_range(0, 9) < 7) return AW'($urandom_range(0, 3));
    return AW'($urandom_range(0, 127));
  endfunction

  initial begin
    clr();
    rst = 1;
    @(posedge clk); #1;
    tick(); tick();
    clr();
    // load-use: lw $5 in EX, add reads $5 in ID
    wreg_e = 5; regwr_e = 1; memrd_e = 1; rs_d = 5; tick();
    clr(); rs_e = 5; wreg_w = 5; regwr_w = 1; tick();
    // load->branch
    clr(); wreg_e = 5; regwr_e = 1; memrd_e = 1; branch_d = 1; rs_d = 5; tick(); tick();
    clr(); tick();
    // MEM beats WB, then zero destination never forwards
    rs_e = 3; wreg_m = 3; regwr_m = 1; wreg_w = 3; regwr_w = 1; tick();
    wreg_m = 0; wreg_w = 0; rs_e = 0; tick();
    // divide lasting 10 cycles
    clr(); mdu_start = 1;
    repeat (10) tick();
    mdu_done = 1; tick();
    clr(); tick();
    // exception in the middle of an ALU->branch bubble run
    wreg_e = 7; regwr_e = 1; branch_d = 1; rt_d = 7; tick(); tick();
    exc_flush = 1; tick();
    clr(); tick(); tick();
    // reset while waiting on the MDU
    mdu_start = 1; tick(); tick();
    rst = 1; tick();
    rst = 0; mdu_start = 0; tick(); tick();
    // random traffic; MDU requests held as a level for realism
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      exc_flush = ($urandom_range(0, 39) == 0);
      exc_stall = ($urandom_range(0, 19) == 0);
      branch_d  = $urandom_range(0, 1);
      rs_d = rid(); rt_d = rid(); rs_e = rid(); rt_e = rid();
      wreg_e = rid(); wreg_m = rid(); wreg_w = rid();
      regwr_e = ($urandom_range(0, 3) != 0); regwr_m = $urandom_range(0, 1);
      regwr_w = $urandom_range(0, 1);
      memrd_e = $urandom_range(0, 1); memrd_m = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) mdu_start = ~mdu_start;
      mdu_done = ($urandom_range(0, 5) == 0);
      tick();
    end
    clr();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
